muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting in EX beside the single-cycle ALU.
- Accepts an operation from the EX stage, iterates a shift-add multiply or a restoring divide one bit per cycle, then applies sign correction.
- Holds the pipeline with `stall` until the result is ready.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; EX holds an M-extension op (Funct7 == 0000001).
- kill  in  1  flush of EX; aborts any operation.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value / dividend.
- op_b  in  XLEN  rs2 value / divisor.
- busy  out  1  state != IDLE.
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle result-valid pulse.
- result  out  XLEN  final value; held until the next accepted start.

Behaviour:
- Reset values: state IDLE, busy 0, stall 0, done 0, result 0, internal registers 0. Reset mid-operation discards the operation silently; no done pulse.
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE:
  - start=1 and kill=0 latches funct3, operand magnitudes and sign flags; counter=XLEN-1; next state CALC.
  - Special divides go straight to SIGN with the result preloaded.
- CALC: one iteration per cycle; at counter==0 go to SIGN, otherwise decrement.
- SIGN: conditional two's-complement negate, select output half, register result; next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE. A start in DONE is ignored; the pipeline re-presents it.
- Latency, with start sampled in cycle 0:
  - Normal ops: done is high in cycle XLEN+2 (34).
  - Special divides: done is high in cycle 2.
- stall: (state ∈ {CALC, SIGN}) OR (state==IDLE AND start AND !kill). Combinational; low during DONE so EX advances and captures result.
- start while state != IDLE is ignored.
- kill has priority over start in any state: next state IDLE, no done, result unchanged.
- Multiply:
  - Operate on magnitudes and form the 2*XLEN product.
  - Negate the product if signs differ. MULH: both operands signed. MULHSU: op_a signed only. MULHU and MUL: unsigned.
  - MUL returns product[XLEN-1:0]; the H variants return product[2XLEN-1:XLEN].
- Divide:
  - Restoring algorithm on magnitudes (signed only for DIV/REM).
  - Quotient negated if signs differ; remainder takes the dividend's sign.
- Special cases:
  - Divisor 0: quotient all-ones; remainder = op_a.
  - Signed overflow (op_a = 0x8000_0000, op_b = -1): quotient 0x8000_0000; remainder 0.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in CALC for multiply ops, if the remaining multiplier shift register is zero, go to SIGN immediately (product already final). Latency becomes variable, with a minimum of 3 cycles (done in cycle 3). done, stall and kill rules are unchanged.
- Undefined: fixed latency XLEN+2 for all non-special ops.

Decomposition:
- Shared package muldiv_pkg:
  - state enum muldiv_state_t.
  - funct3 localparams (F3_MUL..F3_REMU) and the M-extension Funct7 constant 7'b0000001.
  - helper functions is_div(funct3) and op_a_signed/op_b_signed(funct3).
- One sub-module, muldiv_step: combinational single iteration (add-shift or subtract-restore) on {acc, operand register}. The FSM, counter and sign logic stay in muldiv_sequencer.

Test Plan:
- MUL 7 × 0xFFFF_FFFD → result 0xFFFF_FFEB; done in cycle 34 (default build); stall high cycles 0-33, low in 34.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MULH with the same operands → 0x0000_0000. MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
- DIV 0xFFFF_FFF9 / 2 → 0xFFFF_FFFD; REM → 0xFFFF_FFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIV 5 / 0 → 0xFFFF_FFFF, done in cycle 2. REM 5 / 0 → 5. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM → 0.
- Start MUL, re-assert start with different operands at cycle 10 → ignored, original result. kill at cycle 10 → IDLE in cycle 11, no done, result unchanged.
- reset at cycle 20 → all outputs 0 next cycle. A new DIVU 9 / 3 afterwards → 3 in cycle 34. With MULDIV_EARLY_OUT_EN, MUL 5 × 1 → 5, done in cycle 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, funct3/funct7 encodings, operand-signedness helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer decides when to register the outputs.
// Ports: is_div selects the op; acc/opr/b in -> next acc/opr/b out.
//   Multiply: acc = 2*XLEN product, opr = multiplier (consumed LSB first),
//             b = multiplicand shifted left each step.
//   Divide:   acc[XLEN:0] = partial remainder, opr = dividend bits in / quotient
//             bits out (MSB first), b[XLEN-1:0] = divisor (constant).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opr_i,
  input  logic [2*XLEN-1:0] b_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN-1:0]   opr_o,
  output logic [2*XLEN-1:0] b_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {acc_i[XLEN-1:0], opr_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i[XLEN-1:0]};
    acc_o   = acc_i;
    opr_o   = opr_i;
    b_o     = b_i;
    if (is_div) begin
      // Remainder stays below the divisor, so diff[XLEN] is a clean borrow flag.
      acc_o = {{(XLEN-1){1'b0}}, (diff[XLEN] ? shifted : diff)};
      opr_o = {opr_i[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_o = opr_i[0] ? (acc_i + b_i) : acc_i;
      opr_o = opr_i >> 1;
      b_o   = b_i << 1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer beside the EX ALU (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: done in cycle XLEN+2 after start; special divides (x/0, signed overflow) in cycle 2.
// Backpressure: stall holds EX from accepted start through SIGN; start while busy is ignored.
// Ports: clk, reset (sync, active-high), start/kill/funct3/op_a/op_b in;
//        busy/stall/done/result out (result held until the next accepted start completes).
// Build option MULDIV_EARLY_OUT_EN: multiplies leave CALC once the multiplier is exhausted.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opr_q, opr_d;
  logic [2*XLEN-1:0] b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;   // negate product / quotient
  logic              neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              step_div;
  logic [2*XLEN-1:0] step_acc, step_b;
  logic [XLEN-1:0]   step_opr;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem;

  assign step_div = is_div(f3_q);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (step_div),
    .acc_i  (acc_q),
    .opr_i  (opr_q),
    .b_i    (b_q),
    .acc_o  (step_acc),
    .opr_o  (step_opr),
    .b_o    (step_b)
  );

  always_comb begin
    a_neg     = op_a_signed(funct3) & op_a[XLEN-1];
    b_neg     = op_b_signed(funct3) & op_b[XLEN-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    prod      = neg_res_q ? -acc_q : acc_q;
    rem       = acc_q[XLEN-1:0];

    state_d   = state_q;
    f3_d      = f3_q;
    acc_d     = acc_q;
    opr_d     = opr_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          f3_d      = funct3;
          cnt_d     = CW'(XLEN-1);
          acc_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          state_d   = CALC;
          if (is_div(funct3)) begin
            opr_d = a_mag;
            b_d   = {{XLEN{1'b0}}, b_mag};
          end else begin
            opr_d = b_mag;
            b_d   = {{XLEN{1'b0}}, a_mag};
          end
          // Special divides skip CALC: quotient in opr, remainder in acc, no sign fix.
          if (is_div(funct3) && (op_b == '0)) begin
            opr_d     = '1;
            acc_d     = {{XLEN{1'b0}}, op_a};
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = SIGN;
          end else if (is_div(funct3) && op_b_signed(funct3) &&
                       (op_a == MIN_NEG) && (op_b == '1)) begin
            opr_d     = MIN_NEG;
            acc_d     = '0;
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = SIGN;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        opr_d = step_opr;
        b_d   = step_b;
        if (cnt_q == '0) begin
          state_d = SIGN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`ifdef MULDIV_EARLY_OUT_EN
        // No multiplier bits left: the product in acc is already final.
        if (!is_div(f3_q) && (step_opr == '0)) begin
          state_d = SIGN;
        end
`endif
      end
      SIGN: begin
        if (!is_div(f3_q)) begin
          result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (f3_q[1]) begin
          result_d = neg_rem_q ? -rem : rem;
        end else begin
          result_d = neg_res_q ? -opr_q : opr_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      acc_q     <= '0;
      opr_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      acc_q     <= acc_d;
      opr_q     <= opr_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Combinational so EX freezes in the same cycle the op is accepted.
  assign stall  = (state_q == CALC) || (state_q == SIGN) ||
                  ((state_q == IDLE) && start && !kill);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed table-driven bench for muldiv_sequencer.
// Latency: cycle 0 is the cycle in which start is presented.
// Backpressure: stall is checked every cycle until done.
module tb_muldiv_sequencer;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          kind;   // 0 plain, 1 re-start while busy, 2 kill, 3 reset
    int          inj;    // cycle of the injected event
    logic [31:0] res;    // expected result
    int          lat;    // expected done cycle, -1 = no done
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  vec_t tbl[17];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  // Early-out latency: one CALC cycle per multiplier bit up to its highest set bit.
  function automatic int eo_lat(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] m;
    int n;
    m = ((f3 == 3'b001) && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 2;
  endfunction
`endif

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, dc, lat;
    bit stall_bad, idle_bad, pulse_bad;
    logic [31:0] got;
    lat = v.lat;
`ifdef MULDIV_EARLY_OUT_EN
    if (lat > 0 && !v.f3[2]) lat = eo_lat(v.f3, v.b);
`endif
    @(negedge clk);
    funct3 = v.f3; op_a = v.a; op_b = v.b;
    start = 1'b1; kill = 1'b0; reset = 1'b0;
    #1;
    stall_bad = (stall !== 1'b1);
    idle_bad  = 1'b0;
    pulse_bad = 1'b0;
    dc  = -1;
    got = '0;
    cyc = 0;
    while (cyc < 45) begin
      @(negedge clk);
      cyc++;
      if (dc >= 0) begin
        pulse_bad = (done !== 1'b0);
        break;
      end
      if (done === 1'b1) begin
        dc  = cyc;
        got = result;
        if (stall !== 1'b0) stall_bad = 1'b1;
      end else if ((lat > 0 && cyc < lat) || (lat < 0 && cyc <= v.inj)) begin
        if (stall !== 1'b1) stall_bad = 1'b1;
      end
      if (lat < 0 && cyc == v.inj + 1) begin
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        if (v.kind == 3 && result !== 32'h0) idle_bad = 1'b1;
      end
      start = 1'b0; kill = 1'b0; reset = 1'b0;
      if (cyc == v.inj) begin
        case (v.kind)
          1: begin start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd10; end
          2: kill  = 1'b1;
          3: reset = 1'b1;
          default: ;
        endcase
      end
    end
    if (dc < 0) got = result;
    check($sformatf("v%0d_done_cycle", idx), 32'(dc), 32'(lat));
    check($sformatf("v%0d_result", idx), got, v.res);
    check($sformatf("v%0d_stall", idx), {31'b0, stall_bad}, 32'h0);
    if (lat > 0) check($sformatf("v%0d_single_pulse", idx), {31'b0, pulse_bad}, 32'h0);
    else         check($sformatf("v%0d_idle_after_abort", idx), {31'b0, idle_bad}, 32'h0);
  endtask

  initial begin
    tbl[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 0, 0,  32'hFFFF_FFEB, 34};
    tbl[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,  32'hFFFF_FFFE, 34};
    tbl[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,  32'h0000_0000, 34};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         0, 0,  32'hFFFF_FFFF, 34};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         0, 0,  32'hFFFF_FFFD, 34};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         0, 0,  32'hFFFF_FFFF, 34};
    tbl[6]  = '{3'b101, 32'd100,       32'd7,         0, 0,  32'd14,        34};
    tbl[7]  = '{3'b111, 32'd100,       32'd7,         0, 0,  32'd2,         34};
    tbl[8]  = '{3'b000, 32'd3,         32'hFFFF_0000, 2, 10, 32'd2,         -1};
    tbl[9]  = '{3'b100, 32'd5,         32'd0,         0, 0,  32'hFFFF_FFFF, 2};
    tbl[10] = '{3'b110, 32'd5,         32'd0,         0, 0,  32'd5,         2};
    tbl[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,  32'h8000_0000, 2};
    tbl[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,  32'h0000_0000, 2};
    tbl[13] = '{3'b000, 32'd7,         32'hFFFF_FFFD, 1, 10, 32'hFFFF_FFEB, 34};
    tbl[14] = '{3'b000, 32'd7,         32'hFFFF_FFFD, 3, 20, 32'h0000_0000, -1};
    tbl[15] = '{3'b101, 32'd9,         32'd3,         0, 0,  32'd3,         34};
    tbl[16] = '{3'b000, 32'd5,         32'd1,         0, 0,  32'd5,         34};

    reset = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy",   {31'b0, busy},  32'h0);
    check("reset_stall",  {31'b0, stall}, 32'h0);
    check("reset_done",   {31'b0, done},  32'h0);
    check("reset_result", result,         32'h0);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
